// File: rtl/counting_gen_pkg.sv
// Shared symbols, FSM state encoding and phase-sequencing helpers for the
// counting stimulus generator.
package counting_gen_pkg;

  localparam int CW_DEF = 4;

  localparam logic [1:0] SYM_IDLE  = 2'b00;
  localparam logic [1:0] SYM_ONE   = 2'b01;
  localparam logic [1:0] SYM_TWO   = 2'b10;
  localparam logic [1:0] SYM_THREE = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PH1,
    ST_PH2,
    ST_PH3,
    ST_GAP
  } state_t;

  // First non-empty phase of a repetition; GAP when every phase is skipped.
  function automatic state_t first_phase(input logic nz1, input logic nz2, input logic nz3);
    if (nz1)      return ST_PH1;
    else if (nz2) return ST_PH2;
    else if (nz3) return ST_PH3;
    else          return ST_GAP;
  endfunction

  function automatic state_t after_phase(input state_t s, input logic nz2, input logic nz3);
    case (s)
      ST_PH1:  return nz2 ? ST_PH2 : (nz3 ? ST_PH3 : ST_GAP);
      ST_PH2:  return nz3 ? ST_PH3 : ST_GAP;
      default: return ST_GAP;
    endcase
  endfunction

  function automatic logic [1:0] sym_of(input state_t s);
    case (s)
      ST_PH1:  return SYM_ONE;
      ST_PH2:  return SYM_TWO;
      ST_PH3:  return SYM_THREE;
      default: return SYM_IDLE;
    endcase
  endfunction

endpackage

// File: rtl/counting_gen_run_counter.sv
// Loadable down-counter that saturates at zero; reports zero now and zero
// after the current cycle's update.
module run_counter #(
  parameter int CW = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          load,
  input  logic [CW-1:0] load_val,
  input  logic          dec,
  output logic          zero,
  output logic          nxt_zero
);

  logic [CW-1:0] cnt, cnt_nxt;

  always_comb begin
    cnt_nxt = cnt;
    if (load)                  cnt_nxt = load_val;
    else if (dec && cnt != '0) cnt_nxt = cnt - CW'(1);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) cnt <= '0;
    else       cnt <= cnt_nxt;
  end

  assign zero     = (cnt == '0);
  assign nxt_zero = (cnt_nxt == '0);

endmodule

// File: rtl/counting_gen.sv
// Emits 01/10/11 symbol runs plus a gap per repetition, with the detector's
// expected answer, under a start/busy/done handshake.
module counting_gen
  import counting_gen_pkg::*;
#(
  parameter int CW = CW_DEF
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic [CW-1:0] len1,
  input  logic [CW-1:0] len2,
  input  logic [CW-1:0] len3,
  input  logic [CW-1:0] reps,
  output logic [1:0]    num,
  output logic          busy,
  output logic          done,
  output logic          exp_ans
);

  state_t        state, nxt;
  logic [CW-1:0] l1, l2, l3;
  logic [CW-1:0] s1, s2, s3;
  logic          valid;

  logic          run_load, run_dec, run_zero, run_nxt_zero_unused;
  logic [CW-1:0] run_val;
  logic          rep_load, rep_dec, rep_zero, rep_nxt_zero;
  logic [CW-1:0] rep_val;

  always_comb begin
    // Fields come straight from the inputs on the accepting edge.
    s1       = (state == ST_IDLE) ? len1 : l1;
    s2       = (state == ST_IDLE) ? len2 : l2;
    s3       = (state == ST_IDLE) ? len3 : l3;
    nxt      = state;
    run_dec  = 1'b0;
    rep_load = 1'b0;
    rep_dec  = 1'b0;
    // Rep counter holds the repetitions left after the current one.
    rep_val  = (reps == '0) ? '0 : reps - CW'(1);
    case (state)
      ST_IDLE: if (start) begin
        rep_load = 1'b1;
        nxt      = (reps == '0) ? ST_GAP : first_phase(|s1, |s2, |s3);
      end
      ST_PH1, ST_PH2, ST_PH3: begin
        if (run_zero) nxt = after_phase(state, |s2, |s3);
        else          run_dec = 1'b1;
      end
      ST_GAP: begin
        if (rep_zero) nxt = ST_IDLE;
        else begin
          rep_dec = 1'b1;
          nxt     = first_phase(|s1, |s2, |s3);
        end
      end
      default: nxt = ST_IDLE;
    endcase
    run_load = (nxt inside {ST_PH1, ST_PH2, ST_PH3}) && (nxt != state);
    case (nxt)
      ST_PH1:  run_val = s1 - CW'(1);
      ST_PH2:  run_val = s2 - CW'(1);
      ST_PH3:  run_val = s3 - CW'(1);
      default: run_val = '0;
    endcase
  end

  run_counter #(.CW(CW)) u_run (
    .clk      (clk),
    .reset    (reset),
    .load     (run_load),
    .load_val (run_val),
    .dec      (run_dec),
    .zero     (run_zero),
    .nxt_zero (run_nxt_zero_unused)
  );

  run_counter #(.CW(CW)) u_rep (
    .clk      (clk),
    .reset    (reset),
    .load     (rep_load),
    .load_val (rep_val),
    .dec      (rep_dec),
    .zero     (rep_zero),
    .nxt_zero (rep_nxt_zero)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= ST_IDLE;
      l1      <= '0;
      l2      <= '0;
      l3      <= '0;
      valid   <= 1'b0;
      num     <= SYM_IDLE;
      busy    <= 1'b0;
      done    <= 1'b0;
      exp_ans <= 1'b0;
    end else begin
      state <= nxt;
      if (state == ST_IDLE && start) begin
        l1    <= len1;
        l2    <= len2;
        l3    <= len3;
        valid <= (len1 != '0) && (len2 != '0) && (len3 != '0);
      end
      num     <= sym_of(nxt);
      busy    <= (nxt != ST_IDLE);
      // A GAP with no repetitions left behind it is the final cycle.
      done    <= (nxt == ST_GAP) && rep_nxt_zero;
      exp_ans <= (state == ST_PH3) && valid;
    end
  end

endmodule

// File: tb/tb_counting_gen.sv
// Randomized + directed bench for counting_gen against a queue-based model of
// the per-cycle output stream of each accepted request.
module tb_counting_gen;

  localparam int CW = 4;

  logic          clk, reset, start;
  logic [CW-1:0] len1, len2, len3, reps;
  logic [1:0]    num;
  logic          busy, done, exp_ans;

  counting_gen #(.CW(CW)) dut (
    .clk(clk), .reset(reset), .start(start),
    .len1(len1), .len2(len2), .len3(len3), .reps(reps),
    .num(num), .busy(busy), .done(done), .exp_ans(exp_ans)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [1:0] num;
    logic       busy;
    logic       done;
    logic       ans;
  } out_t;

  out_t q[$];
  out_t cur = '0;
  out_t tr[0:15];
  int   n_cmp = 0;
  int   n_bad = 0;

  function automatic out_t mk(input logic [1:0] n, input logic b, input logic d, input logic a);
    return {n, b, d, a};
  endfunction

  task automatic check(input string name, input int act, input int expv);
    n_cmp++;
    if (act != expv) begin
      n_bad++;
      $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, expv);
    end
  endtask

  // Whole output stream of one request; ans echoes "previous symbol was 11 of a
  // fully populated run".
  task automatic build(input int a, input int b, input int c, input int r);
    bit v, p3;
    int len;
    v  = (a != 0) && (b != 0) && (c != 0);
    p3 = 0;
    if (r == 0) q.push_back(mk(2'd0, 1'b1, 1'b1, 1'b0));
    for (int rr = 0; rr < r; rr++) begin
      for (int ph = 1; ph <= 3; ph++) begin
        len = (ph == 1) ? a : (ph == 2) ? b : c;
        for (int i = 0; i < len; i++) begin
          q.push_back(mk(2'(ph), 1'b1, 1'b0, p3));
          p3 = (ph == 3) && v;
        end
      end
      q.push_back(mk(2'd0, 1'b1, rr == r - 1, p3));
      p3 = 0;
    end
  endtask

  initial begin
    forever begin
      @(posedge clk or posedge reset);
      if (reset) begin
        q.delete();
        cur = '0;
      end else if (q.size() > 0) cur = q.pop_front();
      else if (!cur.busy && start) begin
        build(len1, len2, len3, reps);
        cur = q.pop_front();
      end else cur = '0;
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      check("num", num, cur.num);
      check("busy", busy, cur.busy);
      check("done", done, cur.done);
      check("exp_ans", exp_ans, cur.ans);
    end
  end

  task automatic run_req(input int a, input int b, input int c, input int r, input bit hold,
                         output int nb, output int nd, output int ne);
    int k;
    bit fin;
    @(posedge clk); #1;
    len1 = CW'(a); len2 = CW'(b); len3 = CW'(c); reps = CW'(r); start = 1'b1;
    @(posedge clk); #1;
    if (!hold) start = 1'b0;
    nb = 0; nd = 0; ne = 0; k = 0; fin = 0;
    for (int i = 0; i < 16; i++) tr[i] = '0;
    while (!fin && k < 2000) begin
      @(negedge clk);
      k++;
      if (k < 16) tr[k] = {num, busy, done, exp_ans};
      nb += int'(busy); nd += int'(done); ne += int'(exp_ans);
      if (!busy) begin
        fin = 1;
        start = 1'b0;
      end
    end
    if (!fin) check("request_timeout", 1, 0);
    start = 1'b0;
  endtask

  out_t t1[1:7], t3[1:5];
  int   nb, nd, ne;

  initial begin
    reset = 1'b1; start = 1'b0;
    len1 = '0; len2 = '0; len3 = '0; reps = '0;
    t1[1] = mk(2'd1, 1, 0, 0); t1[2] = mk(2'd1, 1, 0, 0); t1[3] = mk(2'd2, 1, 0, 0);
    t1[4] = mk(2'd3, 1, 0, 0); t1[5] = mk(2'd3, 1, 0, 1); t1[6] = mk(2'd0, 1, 1, 1);
    t1[7] = mk(2'd0, 0, 0, 0);
    t3[1] = mk(2'd1, 1, 0, 0); t3[2] = mk(2'd3, 1, 0, 0); t3[3] = mk(2'd3, 1, 0, 0);
    t3[4] = mk(2'd0, 1, 1, 0); t3[5] = mk(2'd0, 0, 0, 0);
    repeat (3) @(posedge clk);
    #1;
    check("rst_num", num, 0); check("rst_busy", busy, 0);
    check("rst_done", done, 0); check("rst_ans", exp_ans, 0);
    @(negedge clk) reset = 1'b0;

    run_req(2, 1, 2, 1, 0, nb, nd, ne);
    for (int k = 1; k <= 7; k++) check($sformatf("s1_cycle%0d", k), tr[k], t1[k]);
    check("s1_busy_cycles", nb, 6);

    run_req(1, 1, 1, 3, 0, nb, nd, ne);
    check("s2_busy_cycles", nb, 12); check("s2_done_pulses", nd, 1);
    check("s2_ans_cycles", ne, 3);
    check("s2_ans_c4", tr[4].ans, 1); check("s2_ans_c8", tr[8].ans, 1);
    check("s2_ans_c12", tr[12].ans, 1); check("s2_done_c12", tr[12].done, 1);

    run_req(1, 0, 2, 1, 0, nb, nd, ne);
    for (int k = 1; k <= 5; k++) check($sformatf("s3_cycle%0d", k), tr[k], t3[k]);

    run_req(3, 2, 1, 0, 1, nb, nd, ne);
    check("s4_cycle1", tr[1], mk(2'd0, 1, 1, 0));
    check("s4_cycle2", tr[2], mk(2'd0, 0, 0, 0));
    check("s4_busy_cycles", nb, 1);

    // Abandon a request mid-flight with an asynchronous reset.
    @(posedge clk); #1;
    len1 = 4'd2; len2 = 4'd1; len3 = 4'd2; reps = 4'd1; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #2 reset = 1'b1;
    #1;
    check("mid_rst_num", num, 0); check("mid_rst_busy", busy, 0);
    check("mid_rst_done", done, 0); check("mid_rst_ans", exp_ans, 0);
    @(negedge clk) reset = 1'b0;
    run_req(2, 1, 2, 1, 0, nb, nd, ne);
    for (int k = 1; k <= 7; k++) check($sformatf("post_rst_cycle%0d", k), tr[k], t1[k]);

    run_req(15, 15, 15, 15, 0, nb, nd, ne);
    check("max_busy_cycles", nb, 690); check("max_done_pulses", nd, 1);
    check("max_ans_cycles", ne, 225);

    for (int i = 0; i < 3000; i++) begin
      @(posedge clk); #1;
      if (reset) reset = 1'b0;
      else if ($urandom_range(0, 499) == 0) reset = 1'b1;
      start = ($urandom_range(0, 4) == 0);
      len1 = CW'(($urandom_range(0, 9) == 0) ? $urandom_range(0, 15) : $urandom_range(0, 3));
      len2 = CW'(($urandom_range(0, 9) == 0) ? $urandom_range(0, 15) : $urandom_range(0, 3));
      len3 = CW'(($urandom_range(0, 9) == 0) ? $urandom_range(0, 15) : $urandom_range(0, 3));
      reps = CW'($urandom_range(0, 3));
    end
    start = 1'b0; reset = 1'b0;
    repeat (800) @(posedge clk);
    @(negedge clk);
    check("final_idle", busy, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
